// File: rtl/npc_mem_arbiter_pkg.sv
// Shared encodings for the NPC memory arbiter: FSM states, owner tags and
// the store byte-strobe patterns also used by the LSU decode.
package npc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    // Byte strobes before shifting by the address offset.
    localparam logic [3:0] MASK_SB = 4'b0001;
    localparam logic [3:0] MASK_SH = 4'b0011;
    localparam logic [3:0] MASK_SW = 4'b1111;

endpackage

// File: rtl/npc_arb_watchdog.sv
// Response watchdog for the NPC memory arbiter: counts cycles spent in an
// outstanding transaction and flags when the limit is reached.
module npc_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Arbiter sharing the single-ported NPC memory between IFU and LSU, one
// transaction outstanding. Optional response watchdog: NPC_ARB_TIMEOUT_EN.
module npc_mem_arbiter
    import npc_mem_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q;

    logic            grant;
    logic            resp_fire;
    logic            timeout_hit;
    logic            timeout_fire;
    logic            busy;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_wen_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [DW/8-1:0] mem_wmask_q;
    logic            ifu_resp_valid_q, lsu_resp_valid_q;
    logic [DW-1:0]   ifu_rdata_q, lsu_rdata_q;

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign grant     = (state_q == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
    assign resp_fire = (state_q == ST_WAIT) && mem_resp_valid;
    // A real response arriving in the expiry cycle wins over the timeout.
    assign timeout_fire = busy && timeout_hit && !resp_fire;

`ifdef NPC_ARB_TIMEOUT_EN
    logic resp_err_q;

    npc_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .run    (busy),
        .expired(timeout_hit)
    );

    assign resp_err = resp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (timeout_fire)       state_d = ST_IDLE;
                else if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT:  if (resp_fire || timeout_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // LSU has fixed priority; grants are only offered in IDLE.
    always_comb begin
        lsu_req_ready = 1'b0;
        ifu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lsu_req_ready = lsu_req_valid;
                ifu_req_ready = ifu_req_valid && !lsu_req_valid;
            end
            ST_ISSUE: mem_req_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q          <= OWN_IFU;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
`ifdef NPC_ARB_TIMEOUT_EN
            resp_err_q       <= 1'b0;
`endif
        end else begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
`ifdef NPC_ARB_TIMEOUT_EN
            resp_err_q       <= timeout_fire;
`endif
            if (grant) begin
                if (lsu_req_valid) begin
                    owner_q     <= OWN_LSU;
                    mem_addr_q  <= lsu_addr;
                    mem_wen_q   <= lsu_wen;
                    mem_wdata_q <= lsu_wdata;
                    mem_wmask_q <= lsu_wmask;
                end else begin
                    owner_q     <= OWN_IFU;
                    mem_addr_q  <= ifu_addr;
                    mem_wen_q   <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_wmask_q <= '0;
                end
            end
            if (resp_fire || timeout_fire) begin
                if (owner_q == OWN_LSU) begin
                    lsu_resp_valid_q <= 1'b1;
                    lsu_rdata_q      <= (timeout_fire || mem_wen_q) ? '0 : mem_rdata;
                end else begin
                    ifu_resp_valid_q <= 1'b1;
                    ifu_rdata_q      <= timeout_fire ? '0 : mem_rdata;
                end
            end
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wmask      = mem_wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed self-checking bench for npc_mem_arbiter; the timeout section is
// compiled only when NPC_ARB_TIMEOUT_EN is defined.
module tb_npc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        resp_err, mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    npc_mem_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_ifu_resp", 32'(ifu_resp_valid), 32'd0);
        chk("rst_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ifu_rdata", ifu_rdata, 32'd0);

        // IFU read, memory ready at once and responding in the first WAIT cycle
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        #1;
        chk("ifu_ready_idle", 32'(ifu_req_ready), 32'd1);
        chk("lsu_ready_idle", 32'(lsu_req_ready), 32'd0);
        tick();
        ifu_req_valid = 0;
        chk("ifu_issue_valid", 32'(mem_req_valid), 32'd1);
        chk("ifu_issue_addr", mem_addr, 32'h8000_0000);
        chk("ifu_issue_wen", 32'(mem_wen), 32'd0);
        chk("ifu_issue_wmask", 32'(mem_wmask), 32'd0);
        tick();
        chk("ifu_wait_valid", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1; mem_rdata = 32'h0010_0093;
        tick();
        mem_resp_valid = 0; mem_req_ready = 0;
        chk("ifu_resp_pulse", 32'(ifu_resp_valid), 32'd1);
        chk("ifu_rdata", ifu_rdata, 32'h0010_0093);
        chk("ifu_no_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        chk("ifu_resp_err", 32'(resp_err), 32'd0);
        tick();
        chk("ifu_pulse_end", 32'(ifu_resp_valid), 32'd0);
        chk("ifu_rdata_hold", ifu_rdata, 32'h0010_0093);

        // LSU store with 5 cycles of downstream backpressure
        lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b1111;
        #1;
        chk("st_lsu_ready", 32'(lsu_req_ready), 32'd1);
        tick();
        lsu_req_valid = 0; lsu_wdata = 32'h0; lsu_addr = 32'h0; lsu_wmask = 4'h0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_addr", mem_addr, 32'h8000_1004);
            chk("bp_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("bp_wmask", 32'(mem_wmask), 32'hF);
            chk("bp_wen", 32'(mem_wen), 32'd1);
            chk("bp_ifu_ready", 32'(ifu_req_ready), 32'd0);
            if (i < 4) tick();
        end
        mem_req_ready = 1; ifu_req_valid = 0;
        tick();
        mem_req_ready = 0;
        chk("st_wait_valid", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 0;
        chk("st_resp_pulse", 32'(lsu_resp_valid), 32'd1);
        chk("st_rdata_zero", lsu_rdata, 32'd0);
        chk("st_no_ifu_resp", 32'(ifu_resp_valid), 32'd0);

        // Contention: LSU load wins, IFU granted in the LSU response cycle
        lsu_wen = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
        #1;
        chk("ct_lsu_ready", 32'(lsu_req_ready), 32'd1);
        chk("ct_ifu_ready", 32'(ifu_req_ready), 32'd0);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        chk("ct_lsu_addr", mem_addr, 32'h8000_2000);
        chk("ct_ifu_wait", 32'(ifu_req_ready), 32'd0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 0;
        #1;
        chk("ct_lsu_pulse", 32'(lsu_resp_valid), 32'd1);
        chk("ct_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("ct_ifu_grant", 32'(ifu_req_ready), 32'd1);
        tick();
        ifu_req_valid = 0;
        chk("ct_ifu_addr", mem_addr, 32'h8000_0010);
        chk("ct_ifu_wen", 32'(mem_wen), 32'd0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h0000_0013;
        tick();
        mem_resp_valid = 0; mem_req_ready = 0;
        chk("ct_ifu_pulse", 32'(ifu_resp_valid), 32'd1);
        chk("ct_ifu_rdata", ifu_rdata, 32'h0000_0013);
        chk("ct_lsu_hold", lsu_rdata, 32'hCAFE_F00D);

        // Stray memory response in IDLE
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp_valid = 0;
        chk("idle_resp_ifu", 32'(ifu_resp_valid), 32'd0);
        chk("idle_resp_lsu", 32'(lsu_resp_valid), 32'd0);

        // Reset while waiting for a response
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000;
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        mem_resp_valid = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_resp_valid = 0;
        chk("rw_lsu_resp", 32'(lsu_resp_valid), 32'd0);
        chk("rw_ifu_resp", 32'(ifu_resp_valid), 32'd0);
        chk("rw_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rw_mem_addr", mem_addr, 32'd0);
        chk("rw_lsu_rdata", lsu_rdata, 32'd0);
        chk("rw_ifu_rdata", ifu_rdata, 32'd0);
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        #1;
        chk("rw_idle_grant", 32'(ifu_req_ready), 32'd1);

`ifdef NPC_ARB_TIMEOUT_EN
        // Watchdog: no response, completion with error 9 edges after the grant
        begin
            int seen;
            seen = 0;
            mem_req_ready = 1;
            tick();
            ifu_req_valid = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                mem_req_ready = 0;
                if (ifu_resp_valid && seen == 0) begin
                    seen = k;
                    chk("to_err", 32'(resp_err), 32'd1);
                    chk("to_rdata", ifu_rdata, 32'd0);
                    break;
                end
            end
            chk("to_latency", 32'(seen), 32'd9);
            mem_resp_valid = 1; mem_rdata = 32'h7777_7777;
            tick();
            mem_resp_valid = 0;
            chk("to_late_ignored", 32'(ifu_resp_valid), 32'd0);
            chk("to_err_clear", 32'(resp_err), 32'd0);
        end
`else
        ifu_req_valid = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npc_mem_arbiter.md
Name: npc_mem_arbiter

Overview:
- Shares the single-ported NPC memory interface between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Selects one requester per transaction, registers its request and drives it downstream with a valid/ready handshake.
- Waits for the memory response and routes read data back to the owner.
- Sits between IFU/LSU and the memory bridge (DPI-C or AXI-lite adapter); only one transaction is outstanding at a time.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 256, response watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  IFU fetch address
- ifu_resp_valid  out  1  one-cycle pulse, IFU read data valid
- ifu_rdata  out  DW  instruction word
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  LSU address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  byte strobes (SB=0001<<off, SH=0011<<off, SW=1111)
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store done
- lsu_rdata  out  DW  load data (0 for stores)
- resp_err  out  1  qualifies either resp_valid; 1 = timed-out transaction
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  AW  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DW  registered write data
- mem_wmask  out  DW/8  registered strobes (0 for reads)
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DW  downstream read data

Behaviour:
- States: IDLE, ISSUE, WAIT. Owner register: IFU or LSU.
- Reset (rst=1 at a clk edge):
  - state=IDLE; all outputs 0; owner=IFU.
  - Any in-flight transaction is abandoned.
  - A mem_resp_valid arriving in IDLE is ignored and produces no upstream pulse.
- IDLE:
  - Grant is combinational: LSU has fixed priority. lsu_req_ready = lsu_req_valid; ifu_req_ready = ifu_req_valid & ~lsu_req_valid.
  - Both ready signals are 0 in all other states.
  - On grant, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0) and the owner, then go to ISSUE.
- ISSUE:
  - mem_req_valid=1 with latched fields held stable.
  - When mem_req_ready=1, go to WAIT; mem_req_valid drops the next cycle.
- WAIT:
  - When mem_resp_valid=1, register the response: owner's resp_valid=1 for exactly the next cycle, rdata=mem_rdata (lsu_rdata forced 0 for stores), resp_err=0.
  - Return to IDLE in the same transition.
  - Upstream responses have no backpressure.
- Latency: grant cycle, ISSUE ≥1 cycle, WAIT ≥1 cycle, response pulse. The minimum is 3 cycles from req_valid to resp_valid when memory is ready and responds immediately.
- Back-to-back: a new grant is allowed in the cycle the resp_valid pulse is asserted (state is IDLE then).
- Simultaneous requests: LSU always wins; IFU stays pending with req_valid held. Starvation is acceptable because the multi-cycle core never has both requesters pending for more than one transaction.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside ISSUE is ignored.
- rdata outputs hold their last value between pulses.

Optional Feature:
- Macro NPC_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - On reaching TIMEOUT_CYCLES, force completion: owner resp_valid=1 for one cycle, resp_err=1, rdata=0, mem_req_valid=0, state→IDLE.
  - A late mem_resp_valid is then ignored.
- Undefined: no counter exists; resp_err is tied 0; a missing response hangs in WAIT indefinitely.

Decomposition:
- Shared package/header holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2)
  - owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1)
  - store-mask constants shared with the LSU decode
- One natural sub-module: npc_arb_watchdog (timeout counter), instantiated only under NPC_ARB_TIMEOUT_EN.

Test Plan:
- IFU read: ifu_req_valid=1, addr=0x80000000, mem ready immediately, rdata=0x00100093 two cycles later → ifu_resp_valid pulses 1 cycle with 0x00100093; lsu_resp_valid stays 0.
- LSU store: lsu addr=0x80001004, wen=1, wdata=0xDEADBEEF, wmask=4'b1111 → mem_* shows exactly these fields while mem_req_valid=1; lsu_resp_valid pulse with lsu_rdata=0.
- Contention: both valid in the same cycle → lsu_req_ready=1, ifu_req_ready=0; IFU is granted on the cycle LSU's resp_valid pulses.
- Backpressure: mem_req_ready held 0 for 5 cycles → mem_req_valid stays 1 with stable addr/wdata/wmask; no upstream ready asserted.
- Reset mid-WAIT: rst=1 for 1 cycle, then mem_resp_valid=1 → no resp_valid pulse; state IDLE; all outputs 0.
- NPC_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, no mem_resp_valid → owner resp_valid with resp_err=1 and rdata=0 on the cycle after the count reaches 8; a subsequent mem_resp_valid is ignored.
